// File: rtl/rvparity_fifo.sv
// Small first-word-fall-through FIFO that stores 16-bit data with an even-parity bit
// generated at write time, with optional per-entry parity inversion for error injection.
module rvparity_fifo #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [15:0]      wr_data,
  input  logic             inj_err,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [15:0]      rd_data,
  output logic             rd_parity,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic        par;
    logic [15:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  assign wr_ready = (count != CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  // Outputs are gated so stale (unreset) storage never shows while empty.
  assign rd_data   = rd_valid ? mem[rd_ptr].data : 16'h0;
  assign rd_parity = rd_valid ? mem[rd_ptr].par  : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_valid && !wr_ready) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; flush drops the same-cycle write.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= '{par: (^wr_data) ^ inj_err, data: wr_data};
  end

endmodule
